// File: rtl/stopwatch_counter.sv
// stopwatch_counter: debounced start/clear buttons drive a 0..9999 tick counter for the display stage.
// Latency: a press acts DEBOUNCE_CYCLES+3 edges after the raw level rises; number is registered with count.
// Backpressure: none; this is a free-running source and the display stage samples number every cycle.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset, highest priority
//   btn_start  raw start/pause pushbutton (high = pressed)
//   btn_clear  raw clear pushbutton (high = pressed)
//   btn_lap    raw lap pushbutton, present only with STOPWATCH_LAP_EN
//   number     current count 0..9999 (frozen while a lap hold is active)
//   running    high while in RUN
//   wrap       one-cycle pulse when the count rolls 9999 -> 0
//
// Optional feature macro: STOPWATCH_LAP_EN (lap hold of the displayed number).

// stopwatch_debounce: two-flop synchroniser + stability counter + rising-edge press pulse.
// Latency: level follows the raw input DEBOUNCE_CYCLES+2 edges after it settles; pulse one cycle later.
// Backpressure: none; o_press is a single-cycle strobe.
module stopwatch_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_press
);

  // Counter only has to reach DEBOUNCE_CYCLES-1 before the level is accepted.
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_prev;
  logic          w_s;

  assign w_s = r_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync       <= 2'b00;
      r_cnt        <= '0;
      r_level      <= 1'b0;
      r_level_prev <= 1'b0;
    end else begin
      r_sync       <= {r_sync[0], i_raw};
      r_level_prev <= r_level;
      if (w_s == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        // This is the DEBOUNCE_CYCLES-th consecutive differing sample.
        r_level <= w_s;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_level & ~r_level_prev;

endmodule

module stopwatch_counter #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int TICK_HZ         = 100,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_clear,
`ifdef STOPWATCH_LAP_EN
  input  logic        btn_lap,
`endif
  output logic [13:0] number,
  output logic        running,
  output logic        wrap
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW       = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_running;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_next;
  logic [13:0] r_count;
  logic [13:0] w_count_next;
  logic        r_wrap;
  logic        w_wrap_next;
  logic        w_tick;
  logic        w_start_p;
  logic        w_clear_p;

  stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (btn_start),
    .o_press (w_start_p)
  );

  stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (btn_clear),
    .o_press (w_clear_p)
  );

  // State register; running is registered from the next state so it
  // changes on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_running <= (w_state_next == S_RUN);
    end
  end

  // Next state: clear beats start when both pulse together.
  always_comb begin
    w_state_next = r_state;
    if (w_clear_p) begin
      w_state_next = S_IDLE;
    end else if (w_start_p) begin
      case (r_state)
        S_IDLE:  w_state_next = S_RUN;
        S_RUN:   w_state_next = S_PAUSE;
        S_PAUSE: w_state_next = S_RUN;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Prescaler/count advance is keyed on the current state only, so a start
  // pulse landing on a tick edge still applies that tick's increment.
  assign w_tick = (r_state == S_RUN) && (r_presc == PW'(TICK_DIV - 1));

  always_comb begin
    w_presc_next = r_presc;
    w_count_next = r_count;
    w_wrap_next  = 1'b0;
    if (w_clear_p) begin
      w_presc_next = '0;
      w_count_next = 14'd0;
    end else if (r_state == S_RUN) begin
      if (w_tick) begin
        w_presc_next = '0;
        if (r_count == 14'd9999) begin
          w_count_next = 14'd0;
          w_wrap_next  = 1'b1;
        end else begin
          w_count_next = r_count + 14'd1;
        end
      end else begin
        w_presc_next = r_presc + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_count <= 14'd0;
      r_wrap  <= 1'b0;
    end else begin
      r_presc <= w_presc_next;
      r_count <= w_count_next;
      r_wrap  <= w_wrap_next;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic        w_lap_p;
  logic        r_hold;
  logic        w_hold_next;
  logic [13:0] r_number;
  logic [13:0] w_number_next;

  stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (btn_lap),
    .o_press (w_lap_p)
  );

  // While unheld r_number mirrors r_count, so keeping r_number on the edge
  // that sets the hold freezes the count value present on that edge.
  always_comb begin
    w_hold_next = r_hold;
    if (w_clear_p) begin
      w_hold_next = 1'b0;
    end else if (w_lap_p && (r_state == S_RUN)) begin
      w_hold_next = ~r_hold;
    end
    w_number_next = w_hold_next ? r_number : w_count_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold   <= 1'b0;
      r_number <= 14'd0;
    end else begin
      r_hold   <= w_hold_next;
      r_number <= w_number_next;
    end
  end

  assign number = r_number;
`else
  assign number = r_count;
`endif

  assign running = r_running;
  assign wrap    = r_wrap;

endmodule

// File: tb/tb_stopwatch_counter.sv
module tb_stopwatch_counter;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DEB     = 4;
  localparam int TDIV    = CLK_HZ / TICK_HZ;
  localparam int MAXC    = 10000;
  localparam int TDIV2   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bs = 1'b0, bc = 1'b0, bl = 1'b0;
  logic b2s = 1'b0, b2c = 1'b0;
  logic [13:0] num, num2;
  logic run, run2, wr, wr2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stopwatch_counter #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (bs),
    .btn_clear (bc),
`ifdef STOPWATCH_LAP_EN
    .btn_lap   (bl),
`endif
    .number    (num),
    .running   (run),
    .wrap      (wr)
  );

  // Fast-tick instance so a full 0..9999 rollover fits in a short run.
  stopwatch_counter #(.CLK_HZ(CLK_HZ), .TICK_HZ(CLK_HZ / TDIV2), .DEBOUNCE_CYCLES(DEB)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .btn_start (b2s),
    .btn_clear (b2c),
`ifdef STOPWATCH_LAP_EN
    .btn_lap   (1'b0),
`endif
    .number    (num2),
    .running   (run2),
    .wrap      (wr2)
  );

  // ---------------- reference model ----------------
  // Debounce: the level flips once the last DEB synchronised samples all
  // disagree with it. Count is time spent in RUN divided by TICK_DIV.
  logic [2:0]     raw;
  logic [1:0]     m_sync [3];
  logic [DEB-1:0] m_hist [3];
  logic           m_lvl  [3];
  logic           m_lvlp [3];
  int             m_state;   // 0 idle, 1 run, 2 pause
  int             m_run;     // edges spent in RUN since last clear
  logic           m_wrap;
  logic           m_hold;
  int             m_frozen;
  int             m_count;
  int             exp_num;
  logic           ps, pc;

  assign raw     = {bl, bc, bs};
  assign ps      = m_lvl[0] & ~m_lvlp[0];
  assign pc      = m_lvl[1] & ~m_lvlp[1];
  assign m_count = (m_run / TDIV) % MAXC;
  assign exp_num = m_hold ? m_frozen : m_count;
`ifdef STOPWATCH_LAP_EN
  logic pl;
  assign pl = m_lvl[2] & ~m_lvlp[2];
`endif

  always @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 3; b++) begin
        m_sync[b] <= 2'b00;
        m_hist[b] <= '0;
        m_lvl[b]  <= 1'b0;
        m_lvlp[b] <= 1'b0;
      end
      m_state  <= 0;
      m_run    <= 0;
      m_wrap   <= 1'b0;
      m_hold   <= 1'b0;
      m_frozen <= 0;
    end else begin
      for (int b = 0; b < 3; b++) begin
        m_sync[b] <= {m_sync[b][0], raw[b]};
        m_hist[b] <= {m_hist[b][DEB-2:0], m_sync[b][1]};
        m_lvlp[b] <= m_lvl[b];
        if ({m_hist[b][DEB-2:0], m_sync[b][1]} == {DEB{~m_lvl[b]}})
          m_lvl[b] <= ~m_lvl[b];
      end
      m_wrap <= 1'b0;
      if (pc) begin
        m_state <= 0;
        m_run   <= 0;
        m_hold  <= 1'b0;
      end else begin
        if (m_state == 1) begin
          m_run <= m_run + 1;
          if ((m_run + 1) % (TDIV * MAXC) == 0) m_wrap <= 1'b1;
        end
        if (ps) m_state <= (m_state == 1) ? 2 : 1;
`ifdef STOPWATCH_LAP_EN
        if (pl && m_state == 1) begin
          m_hold <= ~m_hold;
          if (!m_hold) m_frozen <= m_count;
        end
`endif
      end
    end
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic apply_reset;
    rst = 1'b1; bs = 1'b0; bc = 1'b0; bl = 1'b0; b2s = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Raw input high before edges 1..n; returns on the negedge after edge n.
  task automatic press(input int which, input int n);
    if (which == 0) bs = 1'b1; else if (which == 1) bc = 1'b1; else bl = 1'b1;
    repeat (n) @(negedge clk);
    if (which == 0) bs = 1'b0; else if (which == 1) bc = 1'b0; else bl = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; bs = 1'b0; bc = 1'b0; bl = 1'b0; b2s = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (num !== 14'd0) begin errors++; $display("FAIL reset_number got=%0d want=0", num); end
    checks++; if (run !== 1'b0)  begin errors++; $display("FAIL reset_running got=%b want=0", run); end
    checks++; if (wr !== 1'b0)   begin errors++; $display("FAIL reset_wrap got=%b want=0", wr); end
    rst = 1'b0;
  endtask

  task automatic test_start_latency;
    logic exp_run;
    int   exp_n;
    apply_reset();
    bs = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      @(negedge clk);
      if (e == 20) bs = 1'b0;
      exp_run = (e >= DEB + 3);
      exp_n   = (e >= DEB + 3) ? (e - (DEB + 3)) / TDIV : 0;
      checks++;
      if (run !== exp_run) begin errors++; $display("FAIL latency_running edge=%0d got=%b want=%b", e, run, exp_run); end
      checks++;
      if (num !== 14'(exp_n)) begin errors++; $display("FAIL latency_number edge=%0d got=%0d want=%0d", e, num, exp_n); end
    end
  endtask

  task automatic test_glitch;
    apply_reset();
    press(0, DEB - 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (run !== 1'b0 || num !== 14'd0) begin
        errors++; $display("FAIL glitch cycle=%0d running=%b number=%0d want 0/0", i, run, num);
      end
    end
  endtask

  task automatic test_pause_resume;
    int k;
    apply_reset();
    press(0, 6);
    k = 0;
    while (num !== 14'd37 && k < 600) begin @(negedge clk); k++; end
    checks++; if (num !== 14'd37) begin errors++; $display("FAIL pause_reach37 got=%0d want=37", num); end
    // Pause lands 7 edges from now, prescaler phase 7 of 10.
    press(0, 6);
    @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      checks++;
      if (run !== 1'b0 || num !== 14'd37) begin
        errors++; $display("FAIL pause_hold cycle=%0d running=%b number=%0d want 0/37", i, run, num);
      end
      @(negedge clk);
    end
    // Resume: RUN after edge 7, held phase gives the next tick at edge 10.
    bs = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      @(negedge clk);
      if (e == 6) bs = 1'b0;
      checks++;
      if (run !== (e >= 7)) begin errors++; $display("FAIL resume_running edge=%0d got=%b want=%b", e, run, (e >= 7)); end
      checks++;
      if (num !== ((e >= 10) ? 14'd38 : 14'd37)) begin
        errors++; $display("FAIL resume_number edge=%0d got=%0d want=%0d", e, num, (e >= 10) ? 38 : 37);
      end
    end
  endtask

  task automatic test_clear_start;
    int k;
    apply_reset();
    press(0, 6);
    k = 0;
    while (num !== 14'd12 && k < 400) begin @(negedge clk); k++; end
    checks++; if (num !== 14'd12) begin errors++; $display("FAIL clrstart_reach12 got=%0d want=12", num); end
    bs = 1'b1; bc = 1'b1;
    repeat (6) @(negedge clk);
    bs = 1'b0; bc = 1'b0;
    @(negedge clk);
    checks++; if (run !== 1'b0)  begin errors++; $display("FAIL clrstart_running got=%b want=0", run); end
    checks++; if (num !== 14'd0) begin errors++; $display("FAIL clrstart_number got=%0d want=0", num); end
    repeat (20) @(negedge clk);
    checks++;
    if (run !== 1'b0 || num !== 14'd0) begin
      errors++; $display("FAIL clrstart_discard running=%b number=%0d want 0/0", run, num);
    end
  endtask

  task automatic test_reset_mid_debounce;
    apply_reset();
    press(0, 6);
    repeat (30) @(negedge clk);
    bc = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (num !== 14'd0 || run !== 1'b0 || wr !== 1'b0) begin
      errors++; $display("FAIL rst_mid_debounce number=%0d running=%b wrap=%b want 0/0/0", num, run, wr);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    bc = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (run !== (m_state == 1) || num !== 14'(exp_num)) begin
      errors++; $display("FAIL rst_after_model running=%b number=%0d want %b/%0d", run, num, (m_state == 1), exp_num);
    end
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic test_lap;
    int k;
    apply_reset();
    press(0, 6);
    k = 0;
    while (num !== 14'd20 && k < 400) begin @(negedge clk); k++; end
    checks++; if (num !== 14'd20) begin errors++; $display("FAIL lap_reach20 got=%0d want=20", num); end
    press(2, 6);
    @(negedge clk);
    k = 0;
    while (m_count != 30 && k < 200) begin
      checks++;
      if (num !== 14'd20) begin errors++; $display("FAIL lap_frozen cycle=%0d got=%0d want=20", k, num); end
      @(negedge clk); k++;
    end
    checks++; if (m_count != 30 || run !== 1'b1) begin errors++; $display("FAIL lap_internal running=%b want=1", run); end
    press(2, 6);
    @(negedge clk);
    checks++; if (num !== 14'd30) begin errors++; $display("FAIL lap_release got=%0d want=30", num); end
    press(1, 6);
    @(negedge clk);
    checks++; if (num !== 14'd0 || run !== 1'b0) begin errors++; $display("FAIL lap_clear number=%0d running=%b want 0/0", num, run); end
    press(0, 6);
    repeat (25) @(negedge clk);
    checks++; if (num !== 14'd2) begin errors++; $display("FAIL lap_after_clear got=%0d want=2", num); end
  endtask
`endif

  task automatic test_wrap;
    int k, pulses;
    apply_reset();
    b2s = 1'b1;
    k = 0;
    while (run2 !== 1'b1 && k < 20) begin
      @(negedge clk); k++;
      if (k == 6) b2s = 1'b0;
    end
    b2s = 1'b0;
    checks++; if (k != DEB + 3) begin errors++; $display("FAIL wrap_enter edges=%0d want=%0d", k, DEB + 3); end
    pulses = 0;
    for (int n = 1; n <= 2 * MAXC + 10; n++) begin
      @(negedge clk);
      if (wr2 === 1'b1) pulses++;
      if (n % 97 == 0 || n >= 2 * MAXC - 6) begin
        checks++;
        if (num2 !== 14'((n / TDIV2) % MAXC) || wr2 !== (n == 2 * MAXC) || run2 !== 1'b1) begin
          errors++;
          $display("FAIL wrap_seq n=%0d number=%0d wrap=%b running=%b want %0d/%b/1",
                   n, num2, wr2, run2, (n / TDIV2) % MAXC, (n == 2 * MAXC));
        end
      end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL wrap_pulses got=%0d want=1", pulses); end
  endtask

  task automatic test_random;
    int len [3];
    apply_reset();
    for (int b = 0; b < 3; b++) len[b] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (len[0] == 0) begin bs = 1'($urandom_range(0, 1)); len[0] = $urandom_range(1, 14); end
      if (len[1] == 0) begin bc = ($urandom_range(0, 9) == 0); len[1] = $urandom_range(1, 14); end
      if (len[2] == 0) begin bl = 1'($urandom_range(0, 1)); len[2] = $urandom_range(1, 14); end
      for (int b = 0; b < 3; b++) len[b]--;
      @(negedge clk);
      checks++;
      if (run !== (m_state == 1) || num !== 14'(exp_num) || wr !== m_wrap) begin
        errors++;
        $display("FAIL random cycle=%0d running=%b number=%0d wrap=%b want %b/%0d/%b",
                 cyc, run, num, wr, (m_state == 1), exp_num, m_wrap);
      end
    end
    bs = 1'b0; bc = 1'b0; bl = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_latency();
    test_glitch();
    test_pause_resume();
    test_clear_start();
    test_reset_mid_debounce();
`ifdef STOPWATCH_LAP_EN
    test_lap();
`endif
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
